// File: rtl/mac_pkg.sv
// Shared constants and helpers for the attention MAC column.
// sat() is only referenced when MAC_COL_ACC_SAT_EN is defined.
package mac_pkg;

  localparam int unsigned INST_LOAD = 0;
  localparam int unsigned INST_EXEC = 1;

  localparam int unsigned DEF_BW = 8;
  localparam int unsigned DEF_PR = 8;

  // Full-precision dot product width, never narrower than the accumulator.
  function automatic int unsigned dot_width(int unsigned bw, int unsigned bw_psum,
                                            int unsigned pr);
    int unsigned full;
    full = 2 * bw + $clog2(pr) + 1;
    return (full > bw_psum) ? full : bw_psum;
  endfunction

  // Clamp a signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(logic signed [63:0] v, int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_dot.sv
// Combinational PR-lane signed dot product at full precision.
module mac_dot
  import mac_pkg::*;
#(
  parameter int unsigned BW      = DEF_BW,
  parameter int unsigned BW_PSUM = 2 * BW + 6,
  parameter int unsigned PR      = DEF_PR,
  parameter int unsigned SW      = dot_width(BW, BW_PSUM, PR)
) (
  input  logic [PR*BW-1:0]     a,
  input  logic [PR*BW-1:0]     b,
  output logic signed [SW-1:0] dot
);

  always_comb begin
    logic signed [2*BW-1:0] prod;
    prod = '0;
    dot  = '0;
    for (int i = 0; i < PR; i++) begin
      prod = $signed(a[i*BW +: BW]) * $signed(b[i*BW +: BW]);
      dot  = dot + SW'(prod);
    end
  end

endmodule

// File: rtl/mac_col_acc.sv
// Attention MAC column: NKEY key banks, query-key dot product, accumulate, forward.
// Define MAC_COL_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module mac_col_acc
  import mac_pkg::*;
#(
  parameter int unsigned BW      = DEF_BW,
  parameter int unsigned BW_PSUM = 2 * BW + 6,
  parameter int unsigned PR      = DEF_PR,
  parameter int unsigned COL_ID  = 0,
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned NKEY    = 2,
  localparam int unsigned KSW    = (NKEY > 1) ? $clog2(NKEY) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PR*BW-1:0]          q_in,
  output logic [PR*BW-1:0]          q_out,
  input  logic [1:0]                i_inst,
  input  logic                      i_acc,
  input  logic [KSW-1:0]            i_ksel,
  output logic [1:0]                o_inst,
  output logic                      o_acc,
  output logic [KSW-1:0]            o_ksel,
  output logic signed [BW_PSUM-1:0] out,
  output logic                      out_valid,
  output logic [NKEY-1:0]           key_vld
);

  localparam int unsigned TAP = NUM_COL + 1 - COL_ID;
  localparam int unsigned CW  = $clog2(TAP + 2);
  localparam int unsigned SW  = dot_width(BW, BW_PSUM, PR);

  logic [1:0]                inst_q;
  logic                      acc_q;
  logic [KSW-1:0]            ksel_q;
  logic [PR*BW-1:0]          query_q;
  logic [CW-1:0]             cnt_q;
  logic                      ready_q;
  logic [PR*BW-1:0]          key_q [NKEY];
  logic [NKEY-1:0]           key_vld_q;
  logic                      ex2_q;
  logic                      acc2_q;
  logic [KSW-1:0]            ksel2_q;
  logic signed [BW_PSUM-1:0] accum_q;
  logic signed [BW_PSUM-1:0] accum_d;
  logic                      vld3_q;

  logic                      load;
  logic                      exec;
  logic                      capture;
  logic [KSW-1:0]            ld_sel;
  logic [PR*BW-1:0]          key_use;
  logic signed [SW-1:0]      psum;

  function automatic logic [KSW-1:0] clamp_ksel(logic [KSW-1:0] k);
    return (int'(k) >= int'(NKEY)) ? KSW'(NKEY - 1) : k;
  endfunction

  always_comb begin
    load    = inst_q[INST_LOAD];
    exec    = inst_q[INST_EXEC] & ~inst_q[INST_LOAD];
    ld_sel  = clamp_ksel(ksel_q);
    capture = load & ready_q & (cnt_q == CW'(TAP));
    // An unloaded bank reads as a zero key.
    key_use = key_vld_q[ksel2_q] ? key_q[ksel2_q] : '0;
  end

  mac_dot #(
    .BW      (BW),
    .BW_PSUM (BW_PSUM),
    .PR      (PR),
    .SW      (SW)
  ) u_dot (
    .a   (query_q),
    .b   (key_use),
    .dot (psum)
  );

`ifdef MAC_COL_ACC_SAT_EN
  always_comb begin
    logic signed [63:0] psum_sat;
    logic signed [63:0] sum_wide;
    psum_sat = sat(64'(psum), BW_PSUM);
    sum_wide = acc2_q ? (64'(accum_q) + psum_sat) : psum_sat;
    accum_d  = BW_PSUM'(sat(sum_wide, BW_PSUM));
  end
`else
  always_comb begin
    accum_d = acc2_q ? (accum_q + BW_PSUM'(psum)) : BW_PSUM'(psum);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q    <= '0;
      acc_q     <= 1'b0;
      ksel_q    <= '0;
      query_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      key_vld_q <= '0;
      ex2_q     <= 1'b0;
      acc2_q    <= 1'b0;
      ksel2_q   <= '0;
      accum_q   <= '0;
      vld3_q    <= 1'b0;
      for (int n = 0; n < NKEY; n++) key_q[n] <= '0;
    end else begin
      inst_q <= i_inst;
      acc_q  <= i_acc;
      ksel_q <= i_ksel;
      if (inst_q != 2'b00) query_q <= q_in;

      // Dropping out of a burst re-arms the tap counter for the next one.
      if (!load) begin
        ready_q <= 1'b1;
        cnt_q   <= '0;
      end else if (ready_q) begin
        if (capture) begin
          key_q[ld_sel]     <= q_in;
          key_vld_q[ld_sel] <= 1'b1;
          cnt_q             <= '0;
          ready_q           <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // q_in trails the instruction, so execute controls wait one cycle for query_q.
      ex2_q   <= exec;
      acc2_q  <= acc_q;
      ksel2_q <= clamp_ksel(ksel_q);
      vld3_q  <= ex2_q;
      if (ex2_q) accum_q <= accum_d;
    end
  end

  assign q_out     = query_q;
  assign o_inst    = inst_q;
  assign o_acc     = acc_q;
  assign o_ksel    = ksel_q;
  assign out       = accum_q;
  assign out_valid = vld3_q;
  assign key_vld   = key_vld_q;

endmodule
